// File: rtl/ste_shift_pkg.sv
// Shared definitions for the serializer controller, its shift register
// and anything that needs to decode the controller state.
package ste_shift_pkg;

    // Default word width, shared with the downstream ste_shift_reg.
    localparam int STE_SHIFT_W = 24;

    // Default width of the shift-rate divider.
    localparam int STE_DIV_W = 8;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ste_state_e;

endpackage

// File: rtl/ste_tick_gen.sv
// Shift-rate divider: counts the shift period and flags the cycle in which
// the shift register should advance. The count is loaded while the
// controller is in LOAD and reloaded synchronously on every tick, so a tick
// occurs every DIV+1 cycles while running.
module ste_tick_gen
    import ste_shift_pkg::*;
#(
    parameter int DIV_W = STE_DIV_W
) (
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // Next divider count: clear wins, then initial load, then count down / reload.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr_i) begin
            div_cnt_d = '0;
        end else if (load_i) begin
            div_cnt_d = div_i;
        end else if (run_i) begin
            if (div_cnt_q == '0) begin
                div_cnt_d = div_i;
            end else begin
                div_cnt_d = div_cnt_q - DIV_W'(1);
            end
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // run_i comes from registered state, so the tick has no input-to-output path.
    assign tick_o = run_i && (div_cnt_q == '0);

endmodule

// File: rtl/ste_shift_ctrl.sv
// Serializer controller: accepts a parallel word, then drives load / shift /
// clear strobes for a downstream shift register, one shift every
// clk_div_i+1 cycles, and pulses done_o once the whole word has gone out.
//
// Handshake: a word is taken at a rising edge where valid_i and ready_o are
// both high and abort_i is low. ready_o is high only in IDLE, from the first
// edge after reset release, and not while a clear strobe is pending. valid_i
// and data_i are ignored whenever ready_o is low.
module ste_shift_ctrl
    import ste_shift_pkg::*;
#(
    parameter int SHIFT_W = STE_SHIFT_W,
    parameter int DIV_W   = STE_DIV_W
) (
    input  logic               clk,
    input  logic               reset_ni,
    input  logic [SHIFT_W-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [DIV_W-1:0]   clk_div_i,
    input  logic               abort_i,
    output logic [SHIFT_W-1:0] din_parallel_o,
    output logic               shift_ld_o,
    output logic               shift_en_o,
    output logic               shift_clr_o,
    output logic               busy_o,
    output logic               done_o,
    output ste_state_e         state_o
);

    localparam int CNT_W = (SHIFT_W > 1) ? $clog2(SHIFT_W) : 1;

    ste_state_e         state_q,   state_d;
    logic [SHIFT_W-1:0] word_q,    word_d;
    logic [DIV_W-1:0]   div_q,     div_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               clr_q,     clr_d;
    logic               rdy_en_q,  rdy_en_d;
    logic               accept;
    logic               tick;

    // Divider runs only in SHIFT; it is primed in LOAD and cleared on abort.
    ste_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk      (clk),
        .reset_ni (reset_ni),
        .clr_i    (abort_i),
        .load_i   (state_q == LOAD),
        .run_i    (state_q == SHIFT),
        .div_i    (div_q),
        .tick_o   (tick)
    );

    // Abort in IDLE beats a simultaneous handshake.
    assign accept = ready_o && valid_i && !abort_i;

    // Next-state and datapath update; abort overrides every state.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        clr_d     = abort_i;
        rdy_en_d  = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = data_i;
                    div_d   = clk_div_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bit_cnt_d = CNT_W'(SHIFT_W - 1);
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    if (bit_cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_i) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end
    end

    // State, captured word/divider, bit counter and strobe-source registers.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            word_q    <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            clr_q     <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            clr_q     <= clr_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    // Outputs are decoded from registers only.
    assign ready_o        = (state_q == IDLE) && rdy_en_q && !clr_q;
    assign shift_ld_o     = (state_q == LOAD);
    assign din_parallel_o = (state_q == LOAD) ? word_q : '0;
    assign shift_en_o     = tick;
    assign shift_clr_o    = clr_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign state_o        = state_q;

endmodule

// File: doc/ste_shift_ctrl.md
STE_SHIFT_CTRL -- requirements
Module: ste_shift_ctrl

Interface
REQ-001 Parameter SHIFT_W, default 24, word width in bits; must match the downstream ste_shift_reg.
REQ-002 Parameter DIV_W, default 8, width of the shift-rate divider.
REQ-003 clk  in  1  single system clock; all logic on the rising edge.
REQ-004 reset_ni  in  1  reset, asynchronous, active-low.
REQ-005 data_i  in  SHIFT_W  parallel word to serialize.
REQ-006 valid_i  in  1  data_i valid.
REQ-007 ready_o  out  1  word accepted when valid_i&ready_o at a rising edge.
REQ-008 clk_div_i  in  DIV_W  shift period minus one, in clk cycles.
REQ-009 abort_i  in  1  cancel current word, clear shift register.
REQ-010 din_parallel_o  out  SHIFT_W  load word to shift register.
REQ-011 shift_ld_o  out  1  shift register load strobe.
REQ-012 shift_en_o  out  1  shift register enable strobe.
REQ-013 shift_clr_o  out  1  shift register clear strobe.
REQ-014 busy_o  out  1  high in every state except IDLE.
REQ-015 done_o  out  1  one-cycle pulse, word fully shifted.

Function
REQ-016 FSM states IDLE, LOAD, SHIFT, DONE; all strobes decoded from registered state and counters, no combinational path from inputs to strobes.
REQ-017 IDLE: ready_o=1; on handshake, capture data_i into word_q and clk_div_i into div_q; next state LOAD.
REQ-018 ready_o=0 in LOAD, SHIFT and DONE; valid_i is ignored there.
REQ-019 LOAD (exactly 1 cycle): shift_ld_o=1, din_parallel_o=word_q; load bit_cnt=SHIFT_W-1 and div_cnt=div_q; next state SHIFT.
REQ-020 din_parallel_o=word_q whenever state is LOAD, else all zeros.
REQ-021 SHIFT: shift_en_o=(div_cnt==0).
REQ-022 SHIFT with div_cnt==0: reload div_cnt=div_q.
REQ-023 SHIFT with div_cnt!=0: decrement div_cnt.
REQ-024 At a shift_en_o cycle with bit_cnt==0, next state is DONE; otherwise decrement bit_cnt.
REQ-025 Exactly SHIFT_W shift_en_o pulses per word.
REQ-026 Handshake at edge ending cycle N gives: shift_ld_o in N+1; shift_en_o in cycles N+2+D+k*(D+1) for k=0..SHIFT_W-1, where D=div_q; done_o in the cycle after the last pulse.
REQ-027 DONE (1 cycle): done_o=1; next state IDLE, so ready_o returns one cycle after done_o.
REQ-028 clk_div_i changes after acceptance have no effect until the next word.
REQ-029 D=0 gives back-to-back shift_en_o; D=2**DIV_W-1 is legal; no overflow or wrap of div_cnt beyond reload.
REQ-030 abort_i=1 in any non-IDLE state: next state IDLE, shift_clr_o=1 for exactly the following cycle, no done_o, remaining shift_en_o suppressed.
REQ-031 abort_i in IDLE takes priority over a simultaneous handshake; no word is accepted and shift_clr_o pulses.
REQ-032 abort_i held high: shift_clr_o stays high and ready_o stays low until abort_i deasserts.

Reset
REQ-033 While reset_ni=0: state=IDLE; word_q, div_q, bit_cnt, div_cnt =0.
REQ-034 While reset_ni=0: all strobes, busy_o and done_o =0; ready_o=0.
REQ-035 ready_o rises on the first clk edge after reset release.
REQ-036 Reset mid-word discards the word with no done_o; the downstream register is reset by the same reset_ni.

Structure
REQ-037 Package ste_shift_pkg holds the state enum (IDLE, LOAD, SHIFT, DONE) and the SHIFT_W default constant, shared with the shift register and the bench.
REQ-038 Sub-module ste_tick_gen holds div_cnt and produces the tick (shift_en_o qualifier) with synchronous reload; the FSM and bit_cnt stay in ste_shift_ctrl.

Verification
REQ-039 Send 24'hA5AA5A with D=0 -> shift_ld_o at N+1, 24 consecutive shift_en_o at N+2..N+25, done_o at N+26, serial dout MSB-first equals A5AA5A.
REQ-040 D=3, word 24'h234567 -> shift_en_o at N+5, N+9, ... N+97, done_o at N+98; dout_parallel of a downstream capture reg equals 234567.
REQ-041 valid_i held continuously with words 24'hFFFFFF then 24'h000001 -> second accepted only after done_o, one IDLE cycle between words, no lost or duplicated word.
REQ-042 abort_i after 10th shift_en_o -> shift_clr_o next cycle, no done_o, ready_o=1 following cycle, shift register reads 0.
REQ-043 reset_ni low during SHIFT (async, mid-cycle) -> all outputs 0 immediately, no done_o, next word after release serializes correctly.
REQ-044 clk_div_i changed from 0 to 7 mid-word -> pulse spacing stays 1 cycle until next accepted word.
